// File: rtl/alu_exec_stage.sv
// Execute stage: computes the ALU operation at accept and hands results downstream
// through a 2-entry skid buffer (output register plus skid register).
module alu_exec_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        alucontrol,
    input  logic [DATA_W-1:0] srca,
    input  logic [DATA_W-1:0] srcb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              overflow,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired
);

    // state | meaning
    // EMPTY | output register invalid
    // BUSY  | output register valid, skid register empty
    // FULL  | output and skid registers both valid, input stalled
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic              z;
        logic              ov;
        logic              ill;
    } entry_t;

    localparam int MSB = DATA_W - 1;

    state_t            state_q, state_d;
    entry_t            or_q, sr_q, new_e;
    logic [DATA_W-1:0] sum, diff;
    logic              accept, handoff;
    logic              ld_or_new, ld_or_sr, ld_sr_new;

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign handoff   = out_valid && out_ready;

    assign result   = or_q.res;
    assign zero     = or_q.z;
    assign overflow = or_q.ov;
    assign illegal  = or_q.ill;

    always_comb begin
        new_e = '0;
        sum   = srca + srcb;
        diff  = srca - srcb;
        case (alucontrol)
            3'b000: new_e.res = srca & srcb;
            3'b001: new_e.res = srca | srcb;
            3'b010: begin
                new_e.res = sum;
                new_e.ov  = (srca[MSB] == srcb[MSB]) && (sum[MSB] != srca[MSB]);
            end
            3'b110: begin
                new_e.res = diff;
                new_e.ov  = (srca[MSB] != srcb[MSB]) && (diff[MSB] != srca[MSB]);
            end
            // Direct signed compare; the sign of a-b is wrong when the subtraction overflows.
            3'b111:  new_e.res = {{(DATA_W-1){1'b0}}, ($signed(srca) < $signed(srcb))};
            default: new_e.ill = 1'b1;
        endcase
        new_e.z = (new_e.res == '0);
    end

    always_comb begin
        state_d   = state_q;
        ld_or_new = 1'b0;
        ld_or_sr  = 1'b0;
        ld_sr_new = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    ld_or_new = 1'b1;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (accept && out_ready) begin
                    ld_or_new = 1'b1;
                end else if (accept) begin
                    ld_sr_new = 1'b1;
                    state_d   = ST_FULL;
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    ld_or_sr = 1'b1;
                    state_d  = ST_BUSY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            or_q    <= '0;
            sr_q    <= '0;
            retired <= '0;
        end else begin
            state_q <= state_d;
            if (ld_or_new)
                or_q <= new_e;
            else if (ld_or_sr)
                or_q <= sr_q;
            if (ld_sr_new)
                sr_q <= new_e;
            if (handoff)
                retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed and streaming checks for alu_exec_stage, with a small independent ALU model.
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alucontrol;
    logic [31:0] srca, srcb;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero, overflow, illegal;
    logic [31:0] retired;

    int n_checks = 0;
    int n_errors = 0;
    int exp_ret  = 0;

    alu_exec_stage #(.DATA_W(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .alucontrol(alucontrol), .srca(srca), .srcb(srcb),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .overflow(overflow), .illegal(illegal),
        .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        in_valid   = 1'b1;
        alucontrol = c;
        srca       = a;
        srcb       = b;
    endtask

    // Returns {illegal, overflow, zero, result}; written from 33-bit sign-extended arithmetic.
    function automatic logic [34:0] model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] wide;
        logic [31:0] r;
        logic        ov, ill;
        r = 32'd0; ov = 1'b0; ill = 1'b0;
        case (c)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin
                wide = {a[31], a} + {b[31], b};
                r = wide[31:0];
                ov = wide[32] ^ wide[31];
            end
            3'b110: begin
                wide = {a[31], a} - {b[31], b};
                r = wide[31:0];
                ov = wide[32] ^ wide[31];
            end
            3'b111: begin
                if (a[31] != b[31]) r = {31'd0, a[31]};
                else                r = {31'd0, (a < b)};
            end
            default: ill = 1'b1;
        endcase
        return {ill, ov, (r == 32'd0), r};
    endfunction

    // Single op from EMPTY with out_ready high; expectations given by hand.
    task automatic single_op(input string tag, input logic [2:0] c, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] er, input logic ez,
                             input logic eov, input logic eill);
        out_ready = 1'b1;
        drive(c, a, b);
        tick();
        in_valid = 1'b0;
        check({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, ".result"}, {32'd0, result}, {32'd0, er});
        check({tag, ".zero"}, {63'd0, zero}, {63'd0, ez});
        check({tag, ".ovf"}, {63'd0, overflow}, {63'd0, eov});
        check({tag, ".illegal"}, {63'd0, illegal}, {63'd0, eill});
        tick();
        exp_ret++;
        check({tag, ".drained"}, {63'd0, out_valid}, 64'd0);
    endtask

    logic [31:0] pick_tbl [8] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                                   32'h8000_0000, 32'h5, 32'hDEAD_BEEF, 32'h1234_5678};

    initial begin
        logic [34:0] m;
        logic [2:0]  c;
        logic [31:0] a, b;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alucontrol = 3'b000; srca = 32'd0; srcb = 32'd0;
        tick(); tick();
        rst = 1'b0;
        check("rst.out_valid", {63'd0, out_valid}, 64'd0);
        check("rst.in_ready", {63'd0, in_ready}, 64'd1);
        check("rst.result", {32'd0, result}, 64'd0);
        check("rst.flags", {61'd0, zero, overflow, illegal}, 64'd0);
        check("rst.retired", {32'd0, retired}, 64'd0);

        single_op("add5_7", 3'b010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1'b0);
        check("add5_7.retired", {32'd0, retired}, 64'd1);
        single_op("add_ovf", 3'b010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        single_op("slt_neg", 3'b111, 32'h8000_0000, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0);
        single_op("slt_pos", 3'b111, 32'h1, 32'h8000_0000, 32'h0, 1'b1, 1'b0, 1'b0);
        single_op("sub_zero", 3'b110, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0, 1'b0);
        single_op("sub_ovf", 3'b110, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        single_op("and", 3'b000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0, 1'b0, 1'b0);
        single_op("illegal", 3'b100, 32'd9, 32'd4, 32'd0, 1'b1, 1'b0, 1'b1);
        check("retired.directed", {32'd0, retired}, {32'd0, 32'(exp_ret)});

        // Backpressure: A -> OR, B -> SR, C held off until space frees up.
        out_ready = 1'b0;
        drive(3'b010, 32'd10, 32'd20);
        tick();
        check("bp.ready_busy", {63'd0, in_ready}, 64'd1);
        drive(3'b001, 32'hF0, 32'h0F);
        tick();
        check("bp.ready_full", {63'd0, in_ready}, 64'd0);
        check("bp.A_held", {32'd0, result}, 64'd30);
        drive(3'b110, 32'd100, 32'd1);
        tick();
        check("bp.stall_ready", {63'd0, in_ready}, 64'd0);
        check("bp.A_stable", {32'd0, result}, 64'd30);
        check("bp.retired_hold", {32'd0, retired}, {32'd0, 32'(exp_ret)});
        out_ready = 1'b1;
        tick();
        check("bp.B", {32'd0, result}, 64'hFF);
        check("bp.B_valid", {63'd0, out_valid}, 64'd1);
        tick();
        in_valid = 1'b0;
        check("bp.C", {32'd0, result}, 64'd99);
        tick();
        check("bp.drained", {63'd0, out_valid}, 64'd0);
        exp_ret += 3;
        check("bp.retired", {32'd0, retired}, {32'd0, 32'(exp_ret)});

        // Streaming at full rate.
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            c = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 3) == 0) ? pick_tbl[$urandom_range(0, 7)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? pick_tbl[$urandom_range(0, 7)] : $urandom;
            check("stream.in_ready", {63'd0, in_ready}, 64'd1);
            drive(c, a, b);
            m = model(c, a, b);
            tick();
            check("stream.valid", {63'd0, out_valid}, 64'd1);
            check("stream.out", {29'd0, illegal, overflow, zero, result}, {29'd0, m});
        end
        in_valid = 1'b0;
        tick();
        exp_ret += 100;
        check("stream.drained", {63'd0, out_valid}, 64'd0);
        check("stream.retired", {32'd0, retired}, {32'd0, 32'(exp_ret)});

        // Reset while FULL, with a request still presented during reset.
        out_ready = 1'b0;
        drive(3'b010, 32'd1, 32'd1);
        tick();
        drive(3'b010, 32'd2, 32'd2);
        tick();
        check("mid.full", {63'd0, in_ready}, 64'd0);
        rst = 1'b1;
        drive(3'b001, 32'hAA, 32'h55);
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        check("mid.out_valid", {63'd0, out_valid}, 64'd0);
        check("mid.in_ready", {63'd0, in_ready}, 64'd1);
        check("mid.retired", {32'd0, retired}, 64'd0);
        check("mid.result", {32'd0, result}, 64'd0);
        tick();
        check("mid.idle", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b1;
        drive(3'b110, 32'd50, 32'd8);
        tick();
        in_valid = 1'b0;
        check("mid.first_result", {32'd0, result}, 64'd42);
        check("mid.first_valid", {63'd0, out_valid}, 64'd1);
        tick();
        check("mid.drained", {63'd0, out_valid}, 64'd0);
        check("mid.retired_after", {32'd0, retired}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
